mux_select_sequencer: RTL and testbench
=======================================

Name: mux_select_sequencer

Overview:
Round-robin scheduler that sits directly upstream of the 2-to-4 select decoder / 4x1 mux datapath. It watches four channel request lines, picks the next requesting channel in rotating order, and drives a registered 2-bit select (binary) plus a matching one-hot grant. Each grant is held for a programmable dwell, followed by one dead cycle so mux ownership never overlaps.

Parameters:
N_CH, 4, number of channels (fixed at 4; other values are not supported).
SEL_W, 2, select width (log2 N_CH).
HOLD_W, 4, width of the dwell-count input.

Ports:
clk  in  1  system clock; all state changes on rising edge.
rst  in  1  asynchronous, active-high reset.
enable  in  1  arbitration enable; when low, no new grant is issued and any active grant ends.
req  in  4  per-channel request; bit i = channel i.
hold_cycles  in  HOLD_W  dwell; a grant lasts hold_cycles+1 cycles if its request stays high. Sampled only when a grant is issued.
select  out  SEL_W  registered binary index of the granted (or last granted) channel; feeds the decoder.
grant  out  4  registered one-hot of select while granted, else 4'b0000.
sel_valid  out  1  high exactly while grant is non-zero.
busy  out  1  high in HOLD or GAP state.

Behaviour:
- Reset (async, immediate, also mid-grant): state=IDLE, select=2'b00, grant=4'b0000, sel_valid=0, busy=0, ptr=0, cnt=0.
- State IDLE:
  - If enable=1 and req!=0, pick the first set req bit, searching ptr, ptr+1, ... and wrapping 3 to 0.
  - On the same edge: select=ch, grant=1<<ch, sel_valid=1, cnt=hold_cycles, state moves to HOLD.
  - Latency: request seen at edge k gives grant visible after edge k (one registered cycle).
  - Otherwise stay in IDLE with outputs unchanged: grant=0, and select holds its last value.
- State HOLD, evaluated each edge:
  - If cnt==0, req[select]==0, or enable==0, go to GAP: grant=0, sel_valid=0, ptr=select+1 (mod 4), select holds.
  - Otherwise cnt=cnt-1 and the grant holds.
  - Simultaneous exit conditions have the same single effect.
- State GAP: exactly one cycle, then IDLE unconditionally. Requests are ignored during GAP.
- Timing consequences:
  - Minimum spacing between grants is 2 idle cycles (GAP, then the IDLE evaluation edge).
  - hold_cycles=0 gives a 1-cycle grant.
  - A request withdrawn mid-dwell ends the grant at the next edge.
- Fairness: a just-served channel has the lowest priority at the next arbitration. A channel that holds req continuously is granted again within 3 other grants.
- Changes to hold_cycles during HOLD have no effect on the current grant.
- Invariants:
  - grant is always 0 or one-hot.
  - While sel_valid=1, grant == one-hot(select).
  - busy = (state != IDLE).

Decomposition:
- Package mux_seq_pkg contains:
  - constants N_CH=4 and SEL_W=2;
  - the state enum {IDLE, HOLD, GAP} (2-bit encoding);
  - a function onehot4(sel) returning 4'b0001 / 0010 / 0100 / 1000.
- One combinational sub-module, rr_pick:
  - inputs: req[3:0], ptr[1:0];
  - outputs: found, ch[1:0] (rotating-priority search).
- The top module holds the FSM, cnt, ptr and the output registers.

Test Plan:
1. Async reset: assert rst mid-HOLD between clock edges -> grant=0000, sel_valid=0, select=00, busy=0 immediately, without waiting for a clock edge.
2. Basic dwell: enable=1, hold_cycles=2, req=0101 held -> grant=0001/select=00 for 3 cycles, then 0 for 2 cycles, then grant=0100/select=10 for 3 cycles, then back to ch0.
3. Round robin: req=1111, hold_cycles=0 -> select sequence 00, 01, 10, 11, 00, each grant 1 cycle, separated by 2 dead cycles; grant is never non-one-hot.
4. Early release: hold_cycles=15, ch1 granted, req[1] dropped after 2 grant cycles -> grant=0000 at the next edge; next grant goes to the next requester after ch1 (ch3 if req=1000).
5. Enable gating: req=0010 with enable=0 -> no grant, busy=0. Drop enable mid-HOLD -> grant ends next edge; GAP; no new grant until enable=1.
6. Dwell sampling: grant issued with hold_cycles=1, then changed to 7 during HOLD -> grant still lasts exactly 2 cycles.

Source files
------------

// File: rtl/mux_seq_pkg.sv
// Shared definitions for the mux select sequencer.
//   N_CH / SEL_W / HOLD_W : channel count, select width, dwell-count width
//   state_t               : scheduler state (IDLE, HOLD, GAP)
//   onehot4()             : binary select -> one-hot grant
package mux_seq_pkg;

  localparam int unsigned N_CH   = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned HOLD_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic logic [3:0] onehot4(input logic [1:0] sel);
    logic [3:0] oh;
    case (sel)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      default: oh = 4'b1000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/mux_select_sequencer_rr_pick.sv
// Rotating-priority search over four request lines.
//   req   : per-channel request, bit i = channel i
//   ptr   : channel with highest priority for this search
//   found : at least one request is set
//   ch    : first requesting channel at or after ptr, wrapping 3 -> 0
module rr_pick
  import mux_seq_pkg::*;
(
  input  logic [3:0]       req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] ch
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    found = 1'b0;
    ch    = '0;
    idx   = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx = ptr + SEL_W'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        ch    = idx;
      end
    end
  end

endmodule

// File: rtl/mux_select_sequencer.sv
// Round-robin scheduler driving the select of a 4x1 mux datapath.
// Each grant lasts hold_cycles+1 cycles (shortened if the request drops or
// enable falls), followed by one dead GAP cycle so mux ownership never
// overlaps.
//   clk, rst    : clock, asynchronous active-high reset
//   enable      : arbitration enable; low ends an active grant
//   req         : per-channel request lines
//   hold_cycles : dwell, sampled only when a grant is issued
//   select      : registered binary index of the granted/last granted channel
//   grant       : registered one-hot of select while granted, else 0
//   sel_valid   : high while grant is non-zero
//   busy        : high in HOLD or GAP
module mux_select_sequencer
  import mux_seq_pkg::*;
#(
  parameter int unsigned N_CH   = mux_seq_pkg::N_CH,
  parameter int unsigned SEL_W  = mux_seq_pkg::SEL_W,
  parameter int unsigned HOLD_W = mux_seq_pkg::HOLD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [N_CH-1:0]   req,
  input  logic [HOLD_W-1:0] hold_cycles,
  output logic [SEL_W-1:0]  select,
  output logic [N_CH-1:0]   grant,
  output logic              sel_valid,
  output logic              busy
);

  state_t            state, state_n;
  logic [SEL_W-1:0]  select_n;
  logic [N_CH-1:0]   grant_n;
  logic              valid_n;
  logic [SEL_W-1:0]  ptr, ptr_n;
  logic [HOLD_W-1:0] cnt, cnt_n;

  logic              pick_found;
  logic [SEL_W-1:0]  pick_ch;

  rr_pick u_rr_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .ch    (pick_ch)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      select    <= '0;
      grant     <= '0;
      sel_valid <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      select    <= select_n;
      grant     <= grant_n;
      sel_valid <= valid_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    select_n = select;
    grant_n  = grant;
    valid_n  = sel_valid;
    ptr_n    = ptr;
    cnt_n    = cnt;
    case (state)
      IDLE: begin
        if (enable && pick_found) begin
          select_n = pick_ch;
          grant_n  = onehot4(pick_ch);
          valid_n  = 1'b1;
          cnt_n    = hold_cycles;
          state_n  = HOLD;
        end
      end
      HOLD: begin
        if ((cnt == '0) || !req[select] || !enable) begin
          // Served channel drops to lowest priority for the next search.
          state_n = GAP;
          grant_n = '0;
          valid_n = 1'b0;
          ptr_n   = select + SEL_W'(1);
        end else begin
          cnt_n = cnt - HOLD_W'(1);
        end
      end
      GAP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        valid_n = 1'b0;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mux_select_sequencer.sv
module tb_mux_select_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] hold_cycles = 4'd0;
  logic [1:0] select;
  logic [3:0] grant;
  logic       sel_valid;
  logic       busy;

  mux_select_sequencer #(.N_CH(4), .SEL_W(2), .HOLD_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .req         (req),
    .hold_cycles (hold_cycles),
    .select      (select),
    .grant       (grant),
    .sel_valid   (sel_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       vld;
    logic       bsy;
  } exp_t;

  exp_t expq[$];
  int   glog[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: which channel owns the mux, how many extra cycles remain,
  // whether a dead cycle is pending, and who is first in line next time.
  int m_owner = -1;
  int m_rem   = 0;
  int m_last  = 0;
  int m_next  = 0;
  bit m_gap   = 1'b0;
  int m_c;

  always @(posedge clk) begin : model
    exp_t e;
    if (rst) begin
      m_owner = -1; m_rem = 0; m_last = 0; m_next = 0; m_gap = 1'b0;
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (m_owner >= 0) begin
      if (m_rem == 0 || !req[m_owner] || !enable) begin
        m_next  = (m_owner + 1) % 4;
        m_owner = -1;
        m_gap   = 1'b1;
      end else begin
        m_rem--;
      end
    end else if (enable && req != 4'b0000) begin
      for (int k = 0; k < 4; k++) begin
        m_c = (m_next + k) % 4;
        if (req[m_c]) begin
          m_owner = m_c;
          m_last  = m_c;
          m_rem   = int'(hold_cycles);
          break;
        end
      end
    end
    e.sel = 2'(m_last);
    e.gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    e.vld = (m_owner >= 0);
    e.bsy = (m_owner >= 0) || m_gap;
    expq.push_back(e);
  end

  bit prev_valid = 1'b0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      expq.delete();
      prev_valid = 1'b0;
      chk("reset_outputs", {24'd0, select, grant, sel_valid, busy}, 32'd0);
    end else if (expq.size() == 0) begin
      chk("queue_underflow", 32'd0, 32'd1);
    end else begin
      e = expq.pop_front();
      chk("outputs{sel,gnt,vld,bsy}", {24'd0, select, grant, sel_valid, busy},
          {24'd0, e.sel, e.gnt, e.vld, e.bsy});
      if (sel_valid && !prev_valid) glog.push_back(int'(select));
      prev_valid = sel_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Asserts reset between edges and checks outputs before any clock edge.
  task automatic async_reset();
    rst = 1'b1;
    #1;
    chk("async_reset_immediate", {24'd0, select, grant, sel_valid, busy}, 32'd0);
    tick(1);
    rst = 1'b0;
  endtask

  int rr_exp[5] = '{0, 1, 2, 3, 0};

  initial begin
    tick(2);
    rst = 1'b0;

    // Async reset in the middle of a long dwell on channel 2.
    enable = 1'b1; hold_cycles = 4'd15; req = 4'b0100;
    tick(4);
    async_reset();

    // Basic dwell alternating ch0 / ch2.
    hold_cycles = 4'd2; req = 4'b0101;
    tick(14);
    req = 4'b0000;
    tick(3);

    // Round robin, single-cycle grants.
    async_reset();
    glog.delete();
    hold_cycles = 4'd0; req = 4'b1111;
    tick(16);
    req = 4'b0000;
    tick(2);
    chk("rr_grant_count_ge5", {31'd0, glog.size() >= 5}, 32'd1);
    for (int i = 0; i < 5; i++)
      if (i < glog.size()) chk($sformatf("rr_order[%0d]", i), glog[i], rr_exp[i]);

    // Early release of ch1, next requester after ch1 is ch3.
    async_reset();
    glog.delete();
    hold_cycles = 4'd15; req = 4'b0010;
    tick(2);
    req = 4'b1000;
    tick(6);
    req = 4'b0000;
    tick(3);
    chk("early_release_grants", {31'd0, glog.size() >= 2}, 32'd1);
    if (glog.size() >= 2) begin
      chk("early_release_first", glog[0], 1);
      chk("early_release_second", glog[1], 3);
    end

    // Enable gating.
    enable = 1'b0; req = 4'b0010;
    tick(5);
    enable = 1'b1;
    tick(3);
    enable = 1'b0;
    tick(5);
    enable = 1'b1;
    tick(4);
    req = 4'b0000;
    tick(3);

    // Dwell sampled only at grant issue.
    hold_cycles = 4'd1; req = 4'b0001;
    tick(1);
    hold_cycles = 4'd7;
    tick(8);
    req = 4'b0000;
    tick(3);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      hold_cycles = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
      if ($urandom_range(0, 199) == 0) async_reset();
      else tick(1);
    end

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
